// File: rtl/alu_pkg.sv
// Shared ALU/decoder definitions: op encodings, default width, operand helpers.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SLT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5
  } alu_op_e;

  // Instruction-class opcodes as emitted by the decoder
  localparam logic [3:0] INSN_ALU  = 4'h0;
  localparam logic [3:0] INSN_ALUI = 4'h1;
  localparam logic [3:0] INSN_NOP  = 4'hF;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

  // Arithmetic ops take a signed immediate, logical ops a zero-extended one
  function automatic logic imm_signed(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/reg_file_16.sv
// 16-entry register file: two operand read ports, debug read, one write port, R0 = 0.
module reg_file_16 import alu_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [3:0]       rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [16];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we && (waddr != 4'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    ra_data  = (ra_addr  == 4'd0) ? '0 : regs[ra_addr];
    rb_data  = (rb_addr  == 4'd0) ? '0 : regs[rb_addr];
    dbg_data = (dbg_addr == 4'd0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand read with write-back forwarding, ALU, one-cycle result register, write-back.
module execute_stage import alu_pkg::*; #(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             in_imm,
  input  logic [3:0]       in_op,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [3:0]       in_c,
  input  logic             hold,
  output logic             in_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_dst,
  output logic             res_ovf,
  output logic             res_zero,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] ra_data, rb_data, op_a, op_b, imm_ext, result;
  logic [WIDTH-1:0] sum, diff;
  logic             ovf, wb_en, accept, fwd_a, fwd_b;

  assign in_ready = !hold;
  assign accept   = in_valid && !hold;
  assign wb_en    = res_valid && !hold;

  reg_file_16 #(.WIDTH(WIDTH)) u_rf (
    .CLK      (CLK),
    .RST      (RST),
    .we       (wb_en),
    .waddr    (res_dst),
    .wdata    (res_data),
    .ra_addr  (in_a),
    .ra_data  (ra_data),
    .rb_addr  (in_b),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Writing back on this same edge, so the register file still holds the stale value
  assign fwd_a = FWD_EN && res_valid && (res_dst != 4'd0) && (res_dst == in_a);
  assign fwd_b = FWD_EN && res_valid && (res_dst != 4'd0) && (res_dst == in_b) && !in_imm;

  always_comb begin
    imm_ext = {{(WIDTH-4){imm_signed(in_op) & in_b[3]}}, in_b};
    op_a    = fwd_a ? res_data : ra_data;
    op_b    = in_imm ? imm_ext : (fwd_b ? res_data : rb_data);
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    result  = '0;
    ovf     = 1'b0;
    case (in_op)
      OP_ADD: begin
        result = sum;
        ovf    = add_ovf(op_a[WIDTH-1], op_b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = sub_ovf(op_a[WIDTH-1], op_b[WIDTH-1], diff[WIDTH-1]);
      end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_dst   <= '0;
      res_ovf   <= 1'b0;
      res_zero  <= 1'b0;
    end else if (!hold) begin
      res_valid <= accept && op_legal(in_op);
      if (accept && op_legal(in_op)) begin
        res_data <= result;
        res_dst  <= in_c;
        res_ovf  <= ovf;
        res_zero <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; a second instance without forwarding shows the raw hazard.
module tb_execute_stage;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, in_valid, in_imm, hold;
  logic [3:0]  in_op, in_a, in_b, in_c, dbg_addr;
  logic        in_ready, res_valid, res_ovf, res_zero;
  logic [15:0] res_data, dbg_data;
  logic [3:0]  res_dst;
  logic        nf_in_ready, nf_res_valid, nf_res_ovf, nf_res_zero;
  logic [15:0] nf_res_data, nf_dbg_data;
  logic [3:0]  nf_res_dst;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 CLK = ~CLK;

  execute_stage #(.WIDTH(16), .FWD_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_imm(in_imm), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .hold(hold), .in_ready(in_ready),
    .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst), .res_ovf(res_ovf),
    .res_zero(res_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  execute_stage #(.WIDTH(16), .FWD_EN(1'b0)) dut_nf (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_imm(in_imm), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .hold(hold), .in_ready(nf_in_ready),
    .res_valid(nf_res_valid), .res_data(nf_res_data), .res_dst(nf_res_dst), .res_ovf(nf_res_ovf),
    .res_zero(nf_res_zero), .dbg_addr(dbg_addr), .dbg_data(nf_dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic issue(input logic [3:0] op, input logic imm, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c);
    in_valid = 1'b1; in_op = op; in_imm = imm; in_a = a; in_b = b; in_c = c;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = '0; in_imm = 1'b0; in_a = '0; in_b = '0; in_c = '0;
  endtask

  task automatic dbg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    RST = 1'b1; hold = 1'b0; dbg_addr = '0; idle();
    @(negedge CLK);
    step();
    check("rst_valid", res_valid, 0);
    check("rst_data",  res_data, 0);
    check("rst_zero",  res_zero, 0);
    check("rst_ovf",   res_ovf, 0);
    check("rst_ready", in_ready, 1);

    RST = 1'b0;
    issue(OP_ADD, 1'b1, 4'd0, 4'd5, 4'd1);
    step();
    check("addi_valid", res_valid, 1);
    check("addi_data",  res_data, 16'd5);
    check("addi_dst",   res_dst, 4'd1);
    check("addi_zero",  res_zero, 0);

    issue(OP_ADD, 1'b0, 4'd1, 4'd1, 4'd2);
    step();
    check("fwd_data",   res_data, 16'd10);
    check("nofwd_data", nf_res_data, 16'd0);
    check("nofwd_zero", nf_res_zero, 1);
    dbg("dbg_r1", 4'd1, 16'd5);

    issue(OP_SUB, 1'b1, 4'd0, 4'd1, 4'd4);
    step();
    check("subi_data", res_data, 16'hFFFF);
    check("subi_ovf",  res_ovf, 0);

    issue(OP_SLT, 1'b0, 4'd4, 4'd1, 4'd5);
    step();
    check("slt_data", res_data, 16'd1);

    issue(OP_XOR, 1'b1, 4'd0, 4'hF, 4'd6);
    step();
    check("xori_zext", res_data, 16'h000F);

    issue(OP_ADD, 1'b1, 4'd1, 4'hF, 4'd7);
    step();
    check("addi_sext", res_data, 16'd4);

    issue(OP_OR, 1'b0, 4'd6, 4'd2, 4'd7);
    step();
    check("or_data", res_data, 16'h000F);

    issue(OP_AND, 1'b0, 4'd4, 4'd2, 4'd7);
    step();
    check("and_data", res_data, 16'h000A);

    // R8 = 1, then double it 15 times back to back to reach 0x8000
    issue(OP_ADD, 1'b1, 4'd0, 4'd1, 4'd8);
    step();
    for (int i = 0; i < 15; i++) begin
      issue(OP_ADD, 1'b0, 4'd8, 4'd8, 4'd8);
      step();
    end
    check("dbl_data", res_data, 16'h8000);
    check("add_ovf",  res_ovf, 1);

    issue(OP_SUB, 1'b1, 4'd8, 4'd1, 4'd9);
    step();
    check("sub_ovf_data", res_data, 16'h7FFF);
    check("sub_ovf",      res_ovf, 1);

    issue(OP_ADD, 1'b0, 4'd8, 4'd8, 4'd9);
    step();
    check("wrap_data", res_data, 16'h0000);
    check("wrap_zero", res_zero, 1);
    check("wrap_ovf",  res_ovf, 1);

    issue(OP_ADD, 1'b1, 4'd0, 4'd3, 4'd3);
    step();
    check("h_data", res_data, 16'd3);
    issue(OP_ADD, 1'b1, 4'd0, 4'd2, 4'd10);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("h_valid", res_valid, 1);
      check("h_data",  res_data, 16'd3);
      check("h_dst",   res_dst, 4'd3);
      check("h_ready", in_ready, 0);
      dbg("h_r3", 4'd3, 16'd0);
    end
    hold = 1'b0; idle();
    step();
    check("rel_valid", res_valid, 0);
    dbg("rel_r3", 4'd3, 16'd3);
    dbg("rel_r10", 4'd10, 16'd0);
    step();
    dbg("rel_r3_once", 4'd3, 16'd3);

    issue(OP_ADD, 1'b1, 4'd0, 4'd7, 4'd0);
    step();
    check("r0_data",  res_data, 16'd7);
    check("r0_valid", res_valid, 1);
    idle();
    step();
    dbg("r0_read", 4'd0, 16'd0);

    issue(4'd9, 1'b0, 4'd1, 4'd1, 4'd1);
    step();
    check("ill_valid", res_valid, 0);
    idle();
    step();
    dbg("ill_r1", 4'd1, 16'd5);

    issue(OP_ADD, 1'b1, 4'd0, 4'd3, 4'd5);
    step();
    check("pre_rst_valid", res_valid, 1);
    check("pre_rst_data",  res_data, 16'd3);
    RST = 1'b1; idle();
    step();
    check("mrst_valid", res_valid, 0);
    check("mrst_data",  res_data, 0);
    for (int r = 0; r < 16; r++) dbg("mrst_reg", 4'(r), 16'd0);
    RST = 1'b0;
    step();
    dbg("mrst_r5", 4'd5, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Downstream neighbour of the instruction decoder: consumes decoded fields (ALU op, immediate flag, valid, three 4-bit operand fields) and executes them.
- Holds the 16-entry architectural register file.
- Reads operands and selects immediate or register B, then computes the ALU result.
- Presents the result for one registered cycle, then writes it back to the destination register, with forwarding for back-to-back dependencies.

Parameters:
- WIDTH, 16, datapath and register width in bits.
- FWD_EN, 1, 1 = forward the write-back result into operand reads; 0 = read the register file only (bench uses 0 only for hazard-visibility tests).

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present (decoder isValid)
- in_imm  in  1  operand B is the immediate in in_b
- in_op  in  4  ALU op: 0 ADD, 1 SUB, 2 SLT, 3 AND, 4 OR, 5 XOR; 6..15 illegal
- in_a  in  4  source register A index
- in_b  in  4  source register B index, or 4-bit immediate when in_imm=1
- in_c  in  4  destination register index
- hold  in  1  freeze pipeline
- in_ready  out  1  = !hold
- res_valid  out  1  result register holds a committed instruction
- res_data  out  WIDTH  result value
- res_dst  out  4  destination index of res_data
- res_ovf  out  1  signed overflow of the ADD/SUB that produced res_data; 0 otherwise
- res_zero  out  1  res_data == 0
- dbg_addr  in  4  debug read address
- dbg_data  out  WIDTH  combinational register-file read; no forwarding; R0 reads 0

Behaviour:
- Reset, on a synchronous edge with RST=1:
  - res_valid, res_data, res_dst, res_ovf and res_zero all go to 0.
  - All 16 registers clear to 0.
  - Any in-flight result is dropped and not written back.
  - RST has priority over hold and in_valid.
- Accept: an instruction is taken when in_valid && !hold at the edge.
- Illegal op (6..15) with in_valid=1:
  - Accepted and consumed.
  - res_valid=0 next cycle; no write-back.
- Operand A = R[in_a].
- Operand B = R[in_b] when in_imm=0.
- Operand B when in_imm=1:
  - ADD/SUB/SLT: sign-extended in_b.
  - AND/OR/XOR: zero-extended in_b.
- Results:
  - ADD: A+B.
  - SUB: A-B.
  - SLT: 1 if signed A < signed B, else 0.
  - AND/OR/XOR: bitwise.
  - All results truncate mod 2^WIDTH.
- res_ovf:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
- R0 is hardwired zero:
  - Reads return 0.
  - Write-back to R0 is suppressed, but res_valid/res_data still show the computed value.
- Latency: accepted at edge N, result visible on res_* during cycle N+1.
- Write-back: R[res_dst] <= res_data at the first edge where res_valid=1 and hold=0; exactly one write per instruction.
- Forwarding (FWD_EN=1): when res_valid=1, res_dst!=0 and the index equals in_a, or equals in_b with in_imm=0, the operand takes res_data instead of the register-file value.
- Next-state of res_*:
  - hold=1: res_* and the register file are frozen (no write), and no new instruction is accepted.
  - hold=0, no accept: res_valid goes to 0 next edge (after write-back).
  - hold=0, accept: new result loads the same edge the old result writes back.
- Read/write collision: a write-back and a new operand read of the same register on the same edge resolve via forwarding (new value used). With FWD_EN=0 the old value is used.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants ADD..XOR.
  - Instruction opcode constants shared with the decoder.
  - WIDTH default.
  - Overflow/sign-extension helper functions.
- One sub-module: reg_file_16.
  - 16 x WIDTH registers.
  - Two combinational read ports plus the debug read port.
  - One synchronous write port.
  - R0 held at zero.
  - Synchronous clear on RST.

Test Plan:
- ADDI: after RST, ADD with imm=1, in_b=5, in_a=0, in_c=1 -> next cycle res_valid=1, res_data=5, res_dst=1, res_zero=0; two cycles later dbg_addr=1 gives 5.
- Back-to-back dependency: ADD in_a=1, in_b=1, in_c=2, in_imm=0 issued the cycle after the ADDI -> res_data=10 with FWD_EN=1; with FWD_EN=0 -> res_data=0.
- Signed immediate and SLT:
  - SUB imm=1, in_b=1, in_a=0, in_c=4 -> res_data=0xFFFF, res_ovf=0.
  - Then SLT in_a=4, in_b=1, imm=0 -> res_data=1.
  - XOR imm in_b=0xF with R0 -> 0x000F (zero-extended).
- Hold: assert hold=1 for 3 cycles while res_valid=1 (dst=3) -> res_* stable, in_ready=0, R3 unchanged. Release -> R3 written once, res_valid drops next edge.
- Edge cases:
  - Write to R0 (ADDI in_c=0, imm 7) -> res_data=7 but dbg R0 = 0.
  - Illegal op 9 with in_valid=1 -> res_valid=0, no register change.
- Reset mid-operation: RST=1 at the edge where res_valid=1 (dst=5, data=3) -> R5 stays 0, res_valid=0, all registers 0.
